score_max_sub: RTL and testbench



---
 rtl/score_max_sub.sv | 156 +++++++++++++++
 tb/tb_score_max_sub.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/score_max_sub.sv
// rtl/score_max_sub.sv - row max-subtraction stage feeding the safe-softmax block
//
// Purpose:
//   Collects one row of NUM signed attention scores, one word per cycle.
//   Each score is scaled by an arithmetic right shift of SHIFT bits.
//   The block tracks the row maximum while loading. It then subtracts that
//   maximum from every entry, saturating at the most negative value.
//   The resulting non-positive row is presented in parallel to softmax.
//   O_START is held high until softmax answers with its O_VLD pulse.
//
// Optional feature:
//   SCORE_MASK_EN - adds I_MASK. A masked word stores the most negative value.
//   Masked words take no part in the row maximum unless every word is masked.
//
// Ports:
//   I_CLK      in   clock
//   I_RST_N    in   asynchronous active-low reset
//   I_VLD      in   incoming score valid
//   I_DATA     in   incoming score, signed, D_W bits
//   I_MASK     in   word is masked (only with SCORE_MASK_EN)
//   O_RDY      out  a word is accepted this cycle when I_VLD is high
//   O_START    out  softmax start level, held until I_SM_VLD
//   O_DATA     out  NUM x D_W max-subtracted row
//   I_SM_VLD   in   softmax row-done pulse
module score_max_sub #(
  parameter int D_W   = 8,
  parameter int NUM   = 16,
  parameter int SHIFT = 0
) (
  input  logic           I_CLK,
  input  logic           I_RST_N,
  input  logic           I_VLD,
  input  logic [D_W-1:0] I_DATA,
`ifdef SCORE_MASK_EN
  input  logic           I_MASK,
`endif
  output logic           O_RDY,
  output logic           O_START,
  output logic [D_W-1:0] O_DATA [0:NUM-1],
  input  logic           I_SM_VLD
);

  localparam int CW = $clog2(NUM);
  localparam logic signed [D_W-1:0] MIN_VAL = {1'b1, {(D_W-1){1'b0}}};
  localparam logic signed [D_W:0]   MIN_EXT = {2'b11, {(D_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SUB  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic signed [D_W-1:0]  r_buf [0:NUM-1];
  logic signed [D_W-1:0]  r_max;
  // Set once the current row has seen an unmasked word.
  // Until then r_max holds the all-masked minimum value.
  logic                   r_any;
  logic [CW-1:0]          r_cnt;
  logic                   r_rdy;
  logic                   r_start;
  logic [D_W-1:0]         r_data [0:NUM-1];

  logic signed [D_W-1:0]  w_s;
  logic signed [D_W-1:0]  w_store;
  logic                   w_mask;
  logic                   w_xfer;
  logic                   w_last;
  logic signed [D_W:0]    w_diff [0:NUM-1];
  logic [D_W-1:0]         w_sub  [0:NUM-1];

`ifdef SCORE_MASK_EN
  assign w_mask = I_MASK;
`else
  assign w_mask = 1'b0;
`endif

  // Floor-toward-minus-infinity scaling.
  // The scaled value is the one that is stored and compared.
  assign w_s     = $signed(I_DATA) >>> SHIFT;
  assign w_store = w_mask ? MIN_VAL : w_s;
  assign w_xfer  = I_VLD && r_rdy && (r_state == S_LOAD);
  assign w_last  = (r_cnt == CW'(NUM - 1));

  assign O_RDY   = r_rdy;
  assign O_START = r_start;
  assign O_DATA  = r_data;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:  if (w_xfer && w_last) w_next = S_SUB;
      S_SUB:   w_next = S_HOLD;
      S_HOLD:  if (I_SM_VLD) w_next = S_LOAD;
      default: w_next = S_LOAD;
    endcase
  end

  // Every stored entry is <= r_max, so the difference can only leave the
  // D_W range on the negative side. Only the lower clamp is needed.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      w_diff[i] = {r_buf[i][D_W-1], r_buf[i]} - {r_max[D_W-1], r_max};
      if (w_diff[i] < MIN_EXT) begin
        w_sub[i] = MIN_VAL;
      end else begin
        w_sub[i] = w_diff[i][D_W-1:0];
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_state <= S_LOAD;
      r_max   <= '0;
      r_any   <= 1'b0;
      r_cnt   <= '0;
      r_rdy   <= 1'b0;
      r_start <= 1'b0;
      for (int i = 0; i < NUM; i++) begin
        r_buf[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      // Ready follows the state entered on this edge.
      // This gives one bubble after reset and after the softmax handshake.
      r_rdy   <= (w_next == S_LOAD);
      case (r_state)
        S_LOAD: begin
          if (w_xfer) begin
            r_buf[r_cnt] <= w_store;
            r_cnt        <= w_last ? '0 : r_cnt + 1'b1;
            if (r_cnt == '0) begin
              r_max <= w_mask ? MIN_VAL : w_s;
              r_any <= !w_mask;
            end else if (!w_mask) begin
              if (!r_any || (w_s > r_max)) r_max <= w_s;
              r_any <= 1'b1;
            end
          end
        end
        S_SUB: begin
          for (int i = 0; i < NUM; i++) r_data[i] <= w_sub[i];
          r_start <= 1'b1;
        end
        S_HOLD: begin
          if (I_SM_VLD) r_start <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_max_sub.sv
// tb/tb_score_max_sub.sv - scoreboard bench for score_max_sub (SHIFT=0 and SHIFT=2 instances)
module tb_score_max_sub;

  localparam int D_W = 8;
  localparam int NUM = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld [2];
  logic [7:0] din [2];
  logic       sm  [2];
  logic       msk [2];
  logic       rdy0, st0, rdy1, st1;
  logic [7:0] od0 [0:NUM-1];
  logic [7:0] od1 [0:NUM-1];

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q0 [$];
  logic [127:0] exp_q1 [$];

  always #5 clk = ~clk;

  score_max_sub #(.D_W(D_W), .NUM(NUM), .SHIFT(0)) u_dut0 (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VLD(vld[0]), .I_DATA(din[0]),
`ifdef SCORE_MASK_EN
    .I_MASK(msk[0]),
`endif
    .O_RDY(rdy0), .O_START(st0), .O_DATA(od0), .I_SM_VLD(sm[0])
  );

  score_max_sub #(.D_W(D_W), .NUM(NUM), .SHIFT(2)) u_dut1 (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VLD(vld[1]), .I_DATA(din[1]),
`ifdef SCORE_MASK_EN
    .I_MASK(msk[1]),
`endif
    .O_RDY(rdy1), .O_START(st1), .O_DATA(od1), .I_SM_VLD(sm[1])
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic get_rdy(input int sel);
    return (sel == 0) ? rdy0 : rdy1;
  endfunction

  function automatic logic get_st(input int sel);
    return (sel == 0) ? st0 : st1;
  endfunction

  function automatic logic [127:0] get_od(input int sel);
    logic [127:0] r;
    for (int i = 0; i < NUM; i++) r[i*8 +: 8] = (sel == 0) ? od0[i] : od1[i];
    return r;
  endfunction

  // Reference: scale, take the max of unmasked words, subtract, clamp at -128.
  function automatic logic [127:0] model(input logic [127:0] w, input int shift,
                                         input logic [15:0] m);
    int s [16];
    int mx;
    int d;
    bit any;
    logic [127:0] r;
    any = 1'b0;
    mx  = -128;
    for (int i = 0; i < 16; i++) begin
      if (m[i]) begin
        s[i] = -128;
      end else begin
        s[i] = int'($signed(w[i*8 +: 8])) >>> shift;
        if (!any || s[i] > mx) mx = s[i];
        any = 1'b1;
      end
    end
    for (int i = 0; i < 16; i++) begin
      d = s[i] - mx;
      if (d < -128) d = -128;
      r[i*8 +: 8] = 8'(d);
    end
    return r;
  endfunction

  // Drives the first n words of a row. A complete row pushes its expected result.
  task automatic send_row(input int sel, input logic [127:0] w, input logic [15:0] m,
                          input int shift, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      vld[sel] = 1'b1;
      din[sel] = w[i*8 +: 8];
      msk[sel] = m[i];
      t = 0;
      while (get_rdy(sel) !== 1'b1 && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) check("accept_timeout", 128'd0, 128'd1);
      @(negedge clk);
    end
    vld[sel] = 1'b0;
    msk[sel] = 1'b0;
    if (n == NUM) begin
      if (sel == 0) exp_q0.push_back(model(w, shift, m));
      else          exp_q1.push_back(model(w, shift, m));
    end
  endtask

  task automatic wait_start(input int sel, input string tag);
    int t;
    logic [127:0] e;
    t = 0;
    while (get_st(sel) !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_start"}, 128'(get_st(sel)), 128'd1);
    if ((sel == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
      check({tag, "_sb_empty"}, 128'd0, 128'd1);
    end else begin
      e = (sel == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      check({tag, "_row"}, get_od(sel), e);
    end
  endtask

  task automatic sm_pulse(input int sel, input string tag);
    sm[sel] = 1'b1;
    @(negedge clk);
    sm[sel] = 1'b0;
    check({tag, "_start_low"}, 128'(get_st(sel)), 128'd0);
    check({tag, "_rdy_back"},  128'(get_rdy(sel)), 128'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] w, e, held;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0; din[k] = '0; sm[k] = 1'b0; msk[k] = 1'b0;
    end
    #1;
    check("reset_rdy",   128'(rdy0), 128'd0);
    check("reset_start", 128'(st0),  128'd0);
    check("reset_data",  get_od(0),  128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_after_reset", 128'(rdy0), 128'd1);

    // I_SM_VLD outside S_HOLD must not disturb the load state.
    sm_pulse(0, "stray_sm");

    // Ramp 0..15: each output is i-15.
    for (int i = 0; i < NUM; i++) w[i*8 +: 8] = 8'(i);
    for (int i = 0; i < NUM; i++) e[i*8 +: 8] = 8'(i - 15);
    send_row(0, w, 16'h0, 0, NUM);
    check("ramp_sub_start", 128'(st0),  128'd0);
    check("ramp_sub_rdy",   128'(rdy0), 128'd0);
    @(negedge clk);
    check("ramp_start_t1", 128'(st0), 128'd1);
    wait_start(0, "ramp");
    check("ramp_const", get_od(0), e);
    check("ramp_hold_rdy", 128'(rdy0), 128'd0);
    sm_pulse(0, "ramp_rel");

    // Saturation: 127 then -128s; diffs clamp to 0x80 rather than wrapping.
    w = {{15{8'h80}}, 8'h7F};
    send_row(0, w, 16'h0, 0, NUM);
    wait_start(0, "sat");
    check("sat_const", get_od(0), {{15{8'h80}}, 8'h00});

    // Long hold with upstream pushing data: nothing accepted, outputs frozen.
    held = get_od(0);
    for (int c = 0; c < 40; c++) begin
      vld[0] = 1'b1;
      din[0] = 8'($urandom);
      @(negedge clk);
      check("hold_start", 128'(st0),  128'd1);
      check("hold_rdy",   128'(rdy0), 128'd0);
    end
    vld[0] = 1'b0;
    check("hold_data", get_od(0), held);
    sm_pulse(0, "hold_rel");

    w = {$urandom, $urandom, $urandom, $urandom};
    send_row(0, w, 16'h0, 0, NUM);
    wait_start(0, "indep");
    sm_pulse(0, "indep_rel");

    // Reset during a partial row.
    for (int i = 0; i < NUM; i++) w[i*8 +: 8] = 8'(8'h30 + 8'(i * 3));
    send_row(0, w, 16'h0, 0, 7);
    #2 rst_n = 1'b0;
    #1;
    check("arst_rdy",   128'(rdy0), 128'd0);
    check("arst_start", 128'(st0),  128'd0);
    check("arst_data",  get_od(0),  128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_rdy_back", 128'(rdy0), 128'd1);
    for (int i = 0; i < NUM; i++) w[i*8 +: 8] = 8'(i + 1);
    for (int i = 0; i < NUM; i++) e[i*8 +: 8] = 8'(i - 15);
    send_row(0, w, 16'h0, 0, NUM);
    wait_start(0, "post_rst");
    check("post_rst_const", get_od(0), e);
    sm_pulse(0, "post_rst_rel");

    // SHIFT=2 instance.
    w = {16{8'hFB}};
    send_row(1, w, 16'h0, 2, NUM);
    wait_start(1, "shift_neg5");
    check("shift_neg5_const", get_od(1), 128'd0);
    sm_pulse(1, "shift_neg5_rel");
    w = {16{8'h08}};
    w[3*8 +: 8] = 8'h40;
    e = {16{8'hF2}};
    e[3*8 +: 8] = 8'h00;
    send_row(1, w, 16'h0, 2, NUM);
    wait_start(1, "shift_peak");
    check("shift_peak_const", get_od(1), e);
    sm_pulse(1, "shift_peak_rel");

`ifdef SCORE_MASK_EN
    for (int i = 0; i < NUM; i++) w[i*8 +: 8] = 8'(10 * i);
    for (int i = 0; i < NUM; i++) e[i*8 +: 8] = (i < 8) ? 8'(10 * i - 70) : 8'h80;
    send_row(0, w, 16'hFF00, 0, NUM);
    wait_start(0, "mask_half");
    check("mask_half_const", get_od(0), e);
    sm_pulse(0, "mask_half_rel");
    send_row(0, w, 16'hFFFF, 0, NUM);
    wait_start(0, "mask_all");
    check("mask_all_const", get_od(0), 128'd0);
    sm_pulse(0, "mask_all_rel");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
